// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C slave receive front-end.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      DATA     = 3'd3,
      DATA_ACK = 3'd4,
      IGNORE   = 3'd5
   } i2c_rx_state_e;

   localparam logic I2C_ACK   = 1'b0;
   localparam logic I2C_NACK  = 1'b1;
   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Pin-side and consumer-side signals of the I2C slave receiver.
interface i2c_slave_rx_if;

   logic       scl_i;
   logic       sda_i;
   logic       sda_oe;
   logic [7:0] data_slave_read;
   logic       data_slave_read_valid;
   logic       start;
   logic       stop;
   logic       addr_match;
   logic       busy;
   logic [7:0] byte_cnt;

   modport slave (
      input  scl_i, sda_i,
      output sda_oe, data_slave_read, data_slave_read_valid,
             start, stop, addr_match, busy, byte_cnt
   );

   modport master (
      output scl_i, sda_i,
      input  sda_oe, data_slave_read, data_slave_read_valid,
             start, stop, addr_match, busy, byte_cnt
   );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one bus line plus edge detection against the
// previous synchronised sample. Resets to the idle (high) bus level.
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic pclk,
   input  logic preset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   // shift the raw pad value through the chain; remember the last synced value
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // chain and previous-sample registers, loaded with idle-bus 1s on reset
   always_ff @(posedge pclk) begin
      if (preset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: START/STOP detection, 7-bit address match,
// byte assembly, ACK drive and per-byte valid pulse towards the consumer.
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
   parameter int         SYNC_STAGES = 2
) (
   input  logic           pclk,
   input  logic           preset,
   i2c_slave_rx_if.slave  bus
);

   localparam logic [2:0] ST_IDLE     = IDLE;
   localparam logic [2:0] ST_ADDR     = ADDR;
   localparam logic [2:0] ST_ADDR_ACK = ADDR_ACK;
   localparam logic [2:0] ST_DATA     = DATA;
   localparam logic [2:0] ST_DATA_ACK = DATA_ACK;
   localparam logic [2:0] ST_IGNORE   = IGNORE;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .pclk  (pclk),
      .preset(preset),
      .din   (bus.scl_i),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .pclk  (pclk),
      .preset(preset),
      .din   (bus.sda_i),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   logic [2:0] state_q,    state_d;
   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic [7:0] shift_q,    shift_d;
   logic [7:0] data_q,     data_d;
   logic       valid_q,    valid_d;
   logic       start_q,    start_d;
   logic       stop_q,     stop_d;
   logic       match_q,    match_d;
   logic       busy_q,     busy_d;
   logic [7:0] cnt_q,      cnt_d;
   logic       oe_q,       oe_d;

   // SCL must be high in this and the previous sample (no SCL edge), so
   // simultaneous SDA/SCL changes are treated as ordinary data
   logic start_det, stop_det;
   logic [7:0] shift_in;

   assign start_det = sda_fall & scl_lvl & ~scl_rise;
   assign stop_det  = sda_rise & scl_lvl & ~scl_rise;
   assign shift_in  = {shift_q[6:0], sda_lvl};

   // receive FSM: START/STOP override every state, otherwise step on SCL edges
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      start_d   = 1'b0;
      stop_d    = 1'b0;
      match_d   = match_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      oe_d      = oe_q;

      if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 3'd0;
         cnt_d     = 8'd0;
         match_d   = 1'b0;
         oe_d      = 1'b0;
         busy_d    = 1'b1;
         start_d   = 1'b1;
      end else if (stop_det) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
         match_d = 1'b0;
         stop_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (shift_in[7:1] == SLAVE_ADDR && shift_in[0] == I2C_WRITE)
                        state_d = ST_ADDR_ACK;
                     else
                        state_d = ST_IGNORE;
                  end
               end
            end
            ST_DATA: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     data_d  = shift_in;
                     valid_d = 1'b1;
                     cnt_d   = sat_inc8(cnt_q);
                     state_d = ST_DATA_ACK;
                  end
               end
            end
            // first SCL fall pulls SDA for the ACK slot, second one releases it
            ST_ADDR_ACK, ST_DATA_ACK: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d    = (I2C_ACK == 1'b0);
                     match_d = 1'b1;
                  end else begin
                     oe_d      = 1'b0;
                     state_d   = ST_DATA;
                     bit_cnt_d = 3'd0;
                  end
               end
            end
            ST_IGNORE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // state and output registers, all cleared on reset
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         match_q   <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= 8'd0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         match_q   <= match_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         oe_q      <= oe_d;
      end
   end

   assign bus.sda_oe                = oe_q;
   assign bus.data_slave_read       = data_q;
   assign bus.data_slave_read_valid = valid_q;
   assign bus.start                 = start_q;
   assign bus.stop                  = stop_q;
   assign bus.addr_match            = match_q;
   assign bus.busy                  = busy_q;
   assign bus.byte_cnt              = cnt_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master, transaction-level model of
// expected bytes/ACKs/pulses, and a per-cycle compare process.
module tb_i2c_slave_rx;
   import i2c_pkg::*;

   localparam logic [6:0] SA = 7'h3C;

   logic pclk   = 1'b0;
   logic preset = 1'b1;
   logic scl_m  = 1'b1;
   logic sda_m  = 1'b1;

   always #5 pclk = ~pclk;

   i2c_slave_rx_if bus_if();
   assign bus_if.scl_i = scl_m;
   assign bus_if.sda_i = sda_m & ~bus_if.sda_oe;

   i2c_slave_rx #(.SLAVE_ADDR(SA), .SYNC_STAGES(2)) dut (
      .pclk  (pclk),
      .preset(preset),
      .bus   (bus_if)
   );

   int total = 0;
   int bad   = 0;
   int q     = 6;

   logic       ack_ok = 1'b0;
   logic [7:0] exp_bytes[$];
   int         exp_cnts[$];
   logic [7:0] tx_q[$];
   int         model_cnt = 0;
   logic       model_addressed = 1'b0;
   logic [7:0] last_data = 8'd0;
   int         n_start = 0, n_stop = 0, exp_start = 0, exp_stop = 0;
   logic       pv = 1'b0, ps = 1'b0, pp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare against the transaction model
   always @(negedge pclk) begin
      if (preset) begin
         last_data = 8'd0;
         pv = 1'b0; ps = 1'b0; pp = 1'b0;
      end else begin
         check("sda_oe_outside_ack", bus_if.sda_oe & ~ack_ok, 0);
         if (bus_if.data_slave_read_valid) begin
            check("valid_width", pv, 0);
            check("valid_pending", exp_bytes.size() > 0, 1);
            if (exp_bytes.size() > 0) begin
               logic [7:0] eb;
               int ec;
               eb = exp_bytes.pop_front();
               ec = exp_cnts.pop_front();
               check("rx_byte", bus_if.data_slave_read, eb);
               check("byte_cnt_at_valid", bus_if.byte_cnt, ec);
               last_data = eb;
            end
         end else begin
            check("data_hold", bus_if.data_slave_read, last_data);
         end
         if (bus_if.start) begin
            check("start_width", ps, 0);
            n_start++;
         end
         if (bus_if.stop) begin
            check("stop_width", pp, 0);
            n_stop++;
         end
         pv = bus_if.data_slave_read_valid;
         ps = bus_if.start;
         pp = bus_if.stop;
      end
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic m_start();
      if (!scl_m) begin
         sda_m = 1'b1; wclk(q);
         scl_m = 1'b1; wclk(q);
      end
      sda_m = 1'b0; wclk(q);
      scl_m = 1'b0; wclk(1);
      exp_start++;
      model_cnt = 0;
      model_addressed = 1'b0;
      ack_ok = 1'b0;
   endtask

   task automatic m_stop();
      sda_m = 1'b0; wclk(q);
      scl_m = 1'b1; wclk(q);
      sda_m = 1'b1; wclk(q);
      exp_stop++;
      model_addressed = 1'b0;
   endtask

   // nbits < 8 sends a truncated byte with no ACK slot
   task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                            input int nbits, input logic rst_in_ack);
      for (int i = 0; i < nbits; i++) begin
         sda_m = b[7-i];
         wclk(q);
         if (i == 7 && model_addressed) begin
            if (model_cnt < 255) model_cnt++;
            exp_bytes.push_back(b);
            exp_cnts.push_back(model_cnt);
         end
         scl_m = 1'b1; wclk(q);
         if (i == 7) ack_ok = exp_ack;
         scl_m = 1'b0; wclk(1);
      end
      if (nbits == 8) begin
         sda_m = 1'b1; wclk(q);
         scl_m = 1'b1; wclk(q / 2);
         check("ack_drive", bus_if.sda_oe, exp_ack);
         if (rst_in_ack) begin
            preset = 1'b1; wclk(1);
            preset = 1'b0;
            ack_ok = 1'b0;
            model_addressed = 1'b0;
            check("rst_sda_oe", bus_if.sda_oe, 0);
            check("rst_busy", bus_if.busy, 0);
            check("rst_addr_match", bus_if.addr_match, 0);
            check("rst_byte_cnt", bus_if.byte_cnt, 0);
            check("rst_data", bus_if.data_slave_read, 0);
         end
         wclk(q - q / 2);
         scl_m = 1'b0; wclk(4);
         ack_ok = 1'b0;
      end
   endtask

   task automatic post_checks();
      check("idle_busy", bus_if.busy, 0);
      check("idle_addr_match", bus_if.addr_match, 0);
      check("idle_sda_oe", bus_if.sda_oe, 0);
      check("start_count", n_start, exp_start);
      check("stop_count", n_stop, exp_stop);
      check("byte_cnt_final", bus_if.byte_cnt, model_cnt);
      check("bytes_outstanding", exp_bytes.size(), 0);
   endtask

   task automatic send_addr(input logic [6:0] a, input logic rw);
      logic ok;
      ok = (a == SA) && (rw == I2C_WRITE);
      send_byte({a, rw}, ok, 8, 1'b0);
      model_addressed = ok;
      check("addr_match", bus_if.addr_match, ok);
      check("busy", bus_if.busy, 1);
   endtask

   // full transaction: START, address, bytes from tx_q, STOP
   task automatic xfer(input logic [6:0] a, input logic rw);
      m_start();
      send_addr(a, rw);
      foreach (tx_q[i]) send_byte(tx_q[i], model_addressed, 8, 1'b0);
      m_stop();
      wclk(8);
      post_checks();
   endtask

   initial begin
      int s0;
      wclk(3);
      check("reset_sda_oe", bus_if.sda_oe, 0);
      check("reset_data", bus_if.data_slave_read, 0);
      check("reset_valid", bus_if.data_slave_read_valid, 0);
      check("reset_busy", bus_if.busy, 0);
      check("reset_byte_cnt", bus_if.byte_cnt, 0);
      check("reset_addr_match", bus_if.addr_match, 0);
      preset = 1'b0;
      wclk(4);

      // single byte write
      tx_q = '{8'hA5};
      xfer(SA, I2C_WRITE);
      check("t1_data", bus_if.data_slave_read, 8'hA5);
      check("t1_cnt", bus_if.byte_cnt, 1);

      // three bytes
      tx_q = '{8'h01, 8'h02, 8'h03};
      xfer(SA, I2C_WRITE);
      check("t2_data", bus_if.data_slave_read, 8'h03);
      check("t2_cnt", bus_if.byte_cnt, 3);

      // wrong address
      tx_q = '{8'hFF};
      xfer(7'h3D, I2C_WRITE);
      check("t3_data_kept", bus_if.data_slave_read, 8'h03);
      check("t3_cnt", bus_if.byte_cnt, 0);

      // read request is NACKed
      tx_q = '{8'h55};
      xfer(SA, I2C_READ);

      // partial byte then repeated START
      s0 = n_start;
      m_start();
      send_addr(SA, I2C_WRITE);
      send_byte(8'hB0, 1'b0, 4, 1'b0);
      m_start();
      send_addr(SA, I2C_WRITE);
      send_byte(8'h5A, 1'b1, 8, 1'b0);
      m_stop();
      wclk(8);
      post_checks();
      check("t5_starts", n_start - s0, 2);
      check("t5_data", bus_if.data_slave_read, 8'h5A);
      check("t5_cnt", bus_if.byte_cnt, 1);

      // reset while the slave is driving a data ACK
      m_start();
      send_addr(SA, I2C_WRITE);
      send_byte(8'h11, 1'b1, 8, 1'b1);
      tx_q = '{8'hC3};
      xfer(SA, I2C_WRITE);
      check("t6_data", bus_if.data_slave_read, 8'hC3);
      check("t6_cnt", bus_if.byte_cnt, 1);

      // randomized transactions
      for (int t = 0; t < 12; t++) begin
         int k, n;
         logic [6:0] a;
         logic rw;
         q = $urandom_range(5, 8);
         k = $urandom_range(0, 9);
         if (k < 6) begin
            a = SA; rw = I2C_WRITE;
         end else if (k < 8) begin
            a = SA; rw = I2C_READ;
         end else begin
            a = 7'($urandom_range(0, 127));
            if (a == SA) a = a ^ 7'h01;
            rw = 1'($urandom_range(0, 1));
         end
         n = $urandom_range(0, 4);
         tx_q.delete();
         for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
         xfer(a, rw);
      end

      // byte counter saturation
      q = 5;
      tx_q.delete();
      for (int i = 0; i < 257; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      xfer(SA, I2C_WRITE);
      check("sat_cnt", bus_if.byte_cnt, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
